reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 164 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Purpose : releases NUM_STAGES downstream reset domains in order, with per-stage delay and ack handshake.
// Latency : stage k releases delay_k+1 cycles after its load; each ack wait is at most ACK_TIMEOUT cycles.
// Backpressure: none; acks gate progress, a missing ack times out and is flagged in o_err/o_err_stage.
module reset_sequencer #(
  parameter int NUM_STAGES   = 4,
  parameter int DELAY_W      = 8,
  parameter int ACK_TIMEOUT  = 64,
  parameter int N_FLOP_CROSS = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_sw_rst_req,
  input  logic [NUM_STAGES*DELAY_W-1:0] i_stage_delay,
  input  logic [NUM_STAGES-1:0]         i_stage_ack,
  output logic [NUM_STAGES-1:0]         o_stage_rst_n,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic [$clog2(NUM_STAGES)-1:0] o_err_stage
);

  localparam int IDX_W  = $clog2(NUM_STAGES);
  localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_HOLD, S_DELAY, S_ACK, S_RUN, S_SHUT} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_inc;
  logic [DELAY_W-1:0]      cnt_q, cnt_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        err_stage_q, err_stage_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [N_FLOP_CROSS-1:0] sync_q;
  logic                    rst_sync_n;
  logic [DELAY_W-1:0]      fld_cur, fld_nxt;
  logic                    rel_ev, to_ev, sw_ev, clr_ev, stg_done;

  // Reset synchronizer: clears asynchronously, shifts ones in after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= (sync_q << 1) | N_FLOP_CROSS'(1);
  end

  assign rst_sync_n = sync_q[N_FLOP_CROSS-1];
  assign idx_inc    = idx_q + 1'b1;
  assign fld_cur    = i_stage_delay[idx_q*DELAY_W +: DELAY_W];
  assign fld_nxt    = i_stage_delay[idx_inc*DELAY_W +: DELAY_W];

  // State register and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_HOLD;
      idx_q       <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      rst_q       <= '0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      rst_q       <= rst_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: sequencing, counters, and event strobes for the output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    rel_ev   = 1'b0;
    to_ev    = 1'b0;
    sw_ev    = 1'b0;
    clr_ev   = 1'b0;
    stg_done = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (rst_sync_n) begin
          cnt_d   = fld_cur;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rel_ev  = 1'b1;
          tcnt_d  = '0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (i_stage_ack[idx_q]) begin
          stg_done = 1'b1;
        end else if (tcnt_q == TCNT_MAX) begin
          to_ev    = 1'b1;
          stg_done = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
        if (stg_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_RUN;
          end else begin
            idx_d   = idx_inc;
            cnt_d   = fld_nxt;
            state_d = S_DELAY;
          end
        end
      end
      S_RUN: begin
        if (i_sw_rst_req) begin
          sw_ev   = 1'b1;
          idx_d   = LAST_IDX;
          state_d = S_SHUT;
        end
      end
      S_SHUT: begin
        clr_ev = 1'b1;
        if (idx_q == '0) state_d = S_HOLD;
        else             idx_d   = idx_q - 1'b1;
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    rst_d       = rst_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;
    if (rel_ev)             rst_d[idx_q] = 1'b1;
    if (clr_ev)             rst_d[idx_q] = 1'b0;
    if (state_q == S_HOLD)  rst_d        = '0;
    if (to_ev) begin
      err_d       = 1'b1;
      err_stage_d = idx_q;
    end
    if (sw_ev)              err_d        = 1'b0;
    busy_d = (state_d != S_RUN);
    done_d = (state_d == S_RUN);
  end

  assign o_stage_rst_n = rst_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_err_stage   = err_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose : randomized bench for reset_sequencer against a release-schedule model.
// Latency : model predicts release/complete cycles per stage from delays and ack latencies.
// Backpressure: acks are driven from the model schedule; async reset and sw requests are injected.
module tb_reset_sequencer;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int T   = 64;
  localparam int NF  = 3;
  localparam int NIT = 14;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_sw_rst_req;
  logic [N*DW-1:0] i_stage_delay;
  logic [N-1:0]  i_stage_ack;
  logic [N-1:0]  o_stage_rst_n;
  logic          o_busy, o_done, o_err;
  logic [1:0]    o_err_stage;

  always #5 i_clk = ~i_clk;

  reset_sequencer #(
    .NUM_STAGES(N), .DELAY_W(DW), .ACK_TIMEOUT(T), .N_FLOP_CROSS(NF)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sw_rst_req(i_sw_rst_req),
    .i_stage_delay(i_stage_delay), .i_stage_ack(i_stage_ack),
    .o_stage_rst_n(o_stage_rst_n), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_err_stage(o_err_stage)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: per-sequence schedule, in clock edges counted from the last reset release.
  int e, h, it, c_last, act, act_edge, run_wait, sw_prob, m_err, m_es;
  bit from_shut, in_rst;
  int D[N], L[N], r[N], c[N], ld[N];

  task automatic new_seq(input int hh, input bit fs);
    int d34[N];
    d34 = '{2, 5, 0, 1};
    h = hh;
    from_shut = fs;
    for (int k = 0; k < N; k++) begin
      D[k] = $urandom_range(0, 7);
      if ($urandom_range(0, 5) == 0) D[k] = $urandom_range(8, 20);
      L[k] = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) L[k] = T + $urandom_range(0, 5);
      if (it == 0) begin D[k] = 0; L[k] = 0; end
      if (it == 1) begin D[k] = d34[k]; L[k] = 1; end
      if (it == 2) L[k] = (k == 2) ? T + 3 : 0;
      if (it == 3 && k == 1) D[k] = 5;
    end
    for (int k = 0; k < N; k++) begin
      ld[k] = (k == 0) ? h : c[k-1];
      r[k]  = ld[k] + D[k] + 1;
      c[k]  = r[k] + 1 + ((L[k] < T - 1) ? L[k] : T - 1);
      i_stage_delay[k*DW +: DW] = DW'(D[k]);
    end
    c_last   = c[N-1];
    act      = ($urandom_range(0, 3) == 0) ? 1 : 0;
    if (it < 3 || it == 4) act = 0;
    if (it == 3) act = 1;
    act_edge = (it == 3) ? c[0] + 2 : h - 2 + $urandom_range(0, c_last - h + 5);
    run_wait = $urandom_range(0, 3);
    sw_prob  = (it == 4) ? 3 : 10;
  endtask

  task automatic check_outputs();
    logic [N-1:0] em;
    em = '0;
    if (in_rst) begin
      chk("rst_stage_rst_n", 32'(o_stage_rst_n), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd1);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_err_stage", 32'(o_err_stage), 32'd0);
    end else begin
      for (int k = 0; k < N; k++) begin
        if (e < h) begin
          if (from_shut && e < h - 1 - k) em[k] = 1'b1;
        end else if (e >= r[k]) begin
          em[k] = 1'b1;
        end
      end
      chk("stage_rst_n", 32'(o_stage_rst_n), 32'(em));
      chk("busy", 32'(o_busy), 32'(e < c_last));
      chk("done", 32'(o_done), 32'(e >= c_last));
      chk("err", 32'(o_err), 32'(m_err));
      chk("err_stage", 32'(o_err_stage), 32'(m_es));
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_sw_rst_req = 1'b0; i_stage_ack = '0; i_stage_delay = '0;
    in_rst = 1'b1; e = 0; it = 0; m_err = 0; m_es = 0;
    repeat (2) @(posedge i_clk);
    #1 check_outputs();
    i_rst_n = 1'b1;
    in_rst  = 1'b0;
    new_seq(e + NF + 1, 1'b0);
    while (it < NIT && e < 30000) begin
      @(posedge i_clk);
      e++;
      #1;
      for (int k = 0; k < N; k++)
        if (e == c[k] && L[k] > T - 1) begin m_err = 1; m_es = k; end
      if (from_shut && e == h - N - 1) m_err = 0;
      check_outputs();
      if (act == 1 && e == act_edge) begin
        i_rst_n = 1'b0; i_sw_rst_req = 1'b0; i_stage_ack = '0;
        in_rst = 1'b1; m_err = 0; m_es = 0;
        #1 check_outputs();
        @(posedge i_clk);
        e++;
        #1 check_outputs();
        i_rst_n = 1'b1;
        in_rst  = 1'b0;
        it++;
        new_seq(e + NF + 1, 1'b0);
      end else begin
        for (int k = 0; k < N; k++) begin
          if (e >= h && e >= ld[k]) i_stage_delay[k*DW +: DW] = DW'($urandom);
          if (e >= c[k]) i_stage_ack[k] = 1'($urandom_range(0, 1));
          else           i_stage_ack[k] = (e >= r[k] + L[k]);
        end
        i_sw_rst_req = 1'b0;
        if (act == 0 && e >= c_last + run_wait) begin
          i_sw_rst_req = 1'b1;
          it++;
          new_seq(e + 1 + N + 1, 1'b1);
        end else if (e < c_last && $urandom_range(0, sw_prob - 1) == 0) begin
          i_sw_rst_req = 1'b1;
        end
      end
    end
    if (it < NIT) chk("sequence_budget", 32'(it), 32'(NIT));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
